// File: rtl/pair_frame_interleaver_if.sv
// Lane input streams and merged output stream of the pair frame interleaver.
// The master side feeds both lanes and consumes the merged stream.
interface pair_frame_interleaver_if;
    logic [7:0] in_data1;
    logic       in_valid1;
    logic       in_last1;
    logic       in_ready1;
    logic [7:0] in_data2;
    logic       in_valid2;
    logic       in_last2;
    logic       in_ready2;
    logic [7:0] out_data;
    logic       out_lane;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       len_mismatch;
    logic       err_ovf;

    modport master (
        output in_data1, in_valid1, in_last1,
        output in_data2, in_valid2, in_last2,
        output out_ready,
        input  in_ready1, in_ready2,
        input  out_data, out_lane, out_valid, out_last, len_mismatch, err_ovf
    );

    modport slave (
        input  in_data1, in_valid1, in_last1,
        input  in_data2, in_valid2, in_last2,
        input  out_ready,
        output in_ready1, in_ready2,
        output out_data, out_lane, out_valid, out_last, len_mismatch, err_ovf
    );
endinterface

// File: rtl/pair_frame_interleaver.sv
// Buffers two aligned byte lanes in per-lane FIFOs and merges each pair of frames
// in alternating lane order; flags unequal pair lengths and drops oversize frames.
module pair_frame_interleaver #(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          PAD_EN   = 1'b1,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    pair_frame_interleaver_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [7:0]    in_data [2];
    logic [1:0]    in_valid, in_last, in_ready;
    logic [1:0]    full, wr_fire, rd_fire;
    logic [8:0]    head [2];
    logic [8:0]    mem_q [2][DEPTH];

    logic [PW-1:0] wr_ptr_q [2], wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2], rd_ptr_d [2];
    logic [PW-1:0] start_ptr_q [2], start_ptr_d [2];
    logic [PW-1:0] frm_cnt_q [2], frm_cnt_d [2];
    logic [1:0]    drop_q, drop_d;
    logic          err_ovf_q, err_ovf_d;

    state_t        state_q, state_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_lane_q, out_lane_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          len_mismatch_q, len_mismatch_d;
    logic [1:0]    done_q, done_d;
    logic [PW-1:0] cnt_q [2], cnt_d [2];
    logic          xfer, both_ready, start_pair, load, load_lane;

    assign in_data[0]       = bus.in_data1;
    assign in_data[1]       = bus.in_data2;
    assign in_valid         = {bus.in_valid2, bus.in_valid1};
    assign in_last          = {bus.in_last2, bus.in_last1};
    assign bus.in_ready1    = in_ready[0];
    assign bus.in_ready2    = in_ready[1];
    assign bus.out_data     = out_data_q;
    assign bus.out_lane     = out_lane_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.len_mismatch = len_mismatch_q;
    assign bus.err_ovf      = err_ovf_q;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            full[i]     = (wr_ptr_q[i][ADDR_W] != rd_ptr_q[i][ADDR_W]) &&
                          (wr_ptr_q[i][ADDR_W-1:0] == rd_ptr_q[i][ADDR_W-1:0]);
            in_ready[i] = !full[i] || drop_q[i];
            wr_fire[i]  = in_valid[i] && in_ready[i] && !drop_q[i];
            head[i]     = mem_q[i][rd_ptr_q[i][ADDR_W-1:0]];
        end
    end

    always_comb begin
        err_ovf_d = err_ovf_q;
        for (int unsigned i = 0; i < 2; i++) begin
            wr_ptr_d[i]    = wr_ptr_q[i];
            rd_ptr_d[i]    = rd_ptr_q[i];
            start_ptr_d[i] = start_ptr_q[i];
            frm_cnt_d[i]   = frm_cnt_q[i];
            drop_d[i]      = drop_q[i];
            if (wr_fire[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                if (in_last[i]) start_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (rd_fire[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            case ({wr_fire[i] && in_last[i], rd_fire[i] && head[i][8]})
                2'b10:   frm_cnt_d[i] = frm_cnt_q[i] + 1'b1;
                2'b01:   frm_cnt_d[i] = frm_cnt_q[i] - 1'b1;
                default: ;
            endcase
            // A full FIFO holding no complete frame can only be an oversize frame.
            if (drop_q[i]) begin
                if (in_valid[i] && in_last[i]) drop_d[i] = 1'b0;
            end else if (full[i] && frm_cnt_q[i] == '0) begin
                drop_d[i]   = 1'b1;
                wr_ptr_d[i] = start_ptr_q[i];
                err_ovf_d   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        out_data_d     = out_data_q;
        out_lane_d     = out_lane_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        len_mismatch_d = 1'b0;
        done_d         = done_q;
        cnt_d          = cnt_q;
        rd_fire        = '0;
        load           = 1'b0;
        load_lane      = 1'b0;
        start_pair     = 1'b0;
        xfer           = out_valid_q && bus.out_ready;
        both_ready     = (frm_cnt_q[0] != '0) && (frm_cnt_q[1] != '0);

        case (state_q)
            IDLE: start_pair = both_ready;
            EMIT: begin
                if (xfer) begin
                    if (out_last_q) begin
                        len_mismatch_d = (cnt_q[0] != cnt_q[1]);
                        start_pair     = both_ready;
                        if (!both_ready) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            state_d     = IDLE;
                        end
                    end else begin
                        load      = 1'b1;
                        load_lane = !out_lane_q;
                        if (!PAD_EN && done_q[load_lane]) load_lane = out_lane_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_pair) begin
            state_d   = EMIT;
            done_d    = '0;
            cnt_d[0]  = '0;
            cnt_d[1]  = '0;
            load      = 1'b1;
            load_lane = 1'b0;
        end

        // The head byte is popped when it enters the output register, so done/last are known early.
        if (load) begin
            out_valid_d = 1'b1;
            out_lane_d  = load_lane;
            if (done_d[load_lane]) begin
                out_data_d = PAD_BYTE;
            end else begin
                out_data_d          = head[load_lane][7:0];
                rd_fire[load_lane]  = 1'b1;
                cnt_d[load_lane]    = cnt_d[load_lane] + 1'b1;
                if (head[load_lane][8]) done_d[load_lane] = 1'b1;
            end
            out_last_d = &done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '{default: '0};
            rd_ptr_q       <= '{default: '0};
            start_ptr_q    <= '{default: '0};
            frm_cnt_q      <= '{default: '0};
            cnt_q          <= '{default: '0};
            drop_q         <= '0;
            err_ovf_q      <= 1'b0;
            state_q        <= IDLE;
            out_data_q     <= '0;
            out_lane_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            len_mismatch_q <= 1'b0;
            done_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            start_ptr_q    <= start_ptr_d;
            frm_cnt_q      <= frm_cnt_d;
            cnt_q          <= cnt_d;
            drop_q         <= drop_d;
            err_ovf_q      <= err_ovf_d;
            state_q        <= state_d;
            out_data_q     <= out_data_d;
            out_lane_q     <= out_lane_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            len_mismatch_q <= len_mismatch_d;
            done_q         <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (wr_fire[i]) mem_q[i][wr_ptr_q[i][ADDR_W-1:0]] <= {in_last[i], in_data[i]};
        end
    end
endmodule

// File: tb/tb_pair_frame_interleaver.sv
// Directed bench for pair_frame_interleaver: one padded and one non-padded instance
// share the same lane stimulus; merged bytes are logged as {lane, last, data}.
module tb_pair_frame_interleaver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d1 = '0, d2 = '0;
    logic       v1 = 1'b0, l1 = 1'b0, v2 = 1'b0, l2 = 1'b0, oready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lm_cnt_p = 0, lm_cnt_n = 0, lm_cyc_p = -1, last_cyc_p = -1;
    logic [9:0] obs_p[$];
    logic [9:0] obs_n[$];

    always #5 clk = ~clk;

    pair_frame_interleaver_if bus_p ();
    pair_frame_interleaver_if bus_n ();

    assign bus_p.in_data1 = d1;  assign bus_n.in_data1 = d1;
    assign bus_p.in_valid1 = v1; assign bus_n.in_valid1 = v1;
    assign bus_p.in_last1 = l1;  assign bus_n.in_last1 = l1;
    assign bus_p.in_data2 = d2;  assign bus_n.in_data2 = d2;
    assign bus_p.in_valid2 = v2; assign bus_n.in_valid2 = v2;
    assign bus_p.in_last2 = l2;  assign bus_n.in_last2 = l2;
    assign bus_p.out_ready = oready;
    assign bus_n.out_ready = oready;

    pair_frame_interleaver #(.ADDR_W(5), .PAD_EN(1'b1), .PAD_BYTE(8'h00)) u_pad (
        .clk(clk), .rst(rst), .bus(bus_p)
    );
    pair_frame_interleaver #(.ADDR_W(5), .PAD_EN(1'b0), .PAD_BYTE(8'h00)) u_nopad (
        .clk(clk), .rst(rst), .bus(bus_n)
    );

    always @(negedge clk) begin
        cyc++;
        if (bus_p.out_valid && bus_p.out_ready) begin
            obs_p.push_back({bus_p.out_lane, bus_p.out_last, bus_p.out_data});
            if (bus_p.out_last) last_cyc_p = cyc;
        end
        if (bus_n.out_valid && bus_n.out_ready)
            obs_n.push_back({bus_n.out_lane, bus_n.out_last, bus_n.out_data});
        if (bus_p.len_mismatch) begin lm_cnt_p++; lm_cyc_p = cyc; end
        if (bus_n.len_mismatch) lm_cnt_n++;
    end

    task automatic clear_mon();
        obs_p.delete(); obs_n.delete();
        lm_cnt_p = 0; lm_cnt_n = 0; lm_cyc_p = -1; last_cyc_p = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put1(input logic [7:0] d, input logic last);
        int n = 0;
        d1 = d; l1 = last; v1 = 1'b1;
        @(negedge clk);
        while (!bus_p.in_ready1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL put1_timeout byte %h in_ready1 %b want 1", d, bus_p.in_ready1); end
        @(posedge clk); #1;
        v1 = 1'b0; l1 = 1'b0;
    endtask

    task automatic put2(input logic [7:0] d, input logic last);
        int n = 0;
        d2 = d; l2 = last; v2 = 1'b1;
        @(negedge clk);
        while (!bus_p.in_ready2 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL put2_timeout byte %h in_ready2 %b want 1", d, bus_p.in_ready2); end
        @(posedge clk); #1;
        v2 = 1'b0; l2 = 1'b0;
    endtask

    task automatic wait_out(input int np, input int nn);
        int n = 0;
        while ((obs_p.size() < np || obs_n.size() < nn) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_out_timeout got %0d/%0d bytes want %0d/%0d", obs_p.size(), obs_n.size(), np, nn);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_p.out_valid, bus_p.out_data, bus_p.out_lane, bus_p.out_last, bus_p.len_mismatch,
             bus_p.err_ovf, bus_p.in_ready1, bus_p.in_ready2} !== {1'b0, 8'h00, 4'b0000, 2'b11})
            begin errors++; $display("FAIL reset_pad got v%b d%h ln%b la%b lm%b ov%b r%b%b want all 0, ready 11",
                bus_p.out_valid, bus_p.out_data, bus_p.out_lane, bus_p.out_last, bus_p.len_mismatch,
                bus_p.err_ovf, bus_p.in_ready1, bus_p.in_ready2); end
        checks++;
        if ({bus_n.out_valid, bus_n.out_data, bus_n.out_lane, bus_n.out_last, bus_n.len_mismatch,
             bus_n.err_ovf, bus_n.in_ready1, bus_n.in_ready2} !== {1'b0, 8'h00, 4'b0000, 2'b11})
            begin errors++; $display("FAIL reset_nopad got v%b d%h ovf%b r%b%b want 0 00 0 11",
                bus_n.out_valid, bus_n.out_data, bus_n.err_ovf, bus_n.in_ready1, bus_n.in_ready2); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_equal_frames();
        logic [9:0] exp[$];
        exp = '{10'h011, 10'h221, 10'h012, 10'h222, 10'h013, 10'h323};
        clear_mon();
        oready = 1'b1;
        put1(8'h11, 1'b0); put1(8'h12, 1'b0); put1(8'h13, 1'b1);
        put2(8'h21, 1'b0); put2(8'h22, 1'b0); put2(8'h23, 1'b1);
        @(negedge clk);
        checks++;
        if (bus_p.out_valid !== 1'b0) begin errors++; $display("FAIL t1_latency_early out_valid %b want 0", bus_p.out_valid); end
        @(negedge clk);
        checks++;
        if ({bus_p.out_valid, bus_p.out_lane, bus_p.out_data} !== {1'b1, 1'b0, 8'h11})
            begin errors++; $display("FAIL t1_first got v%b lane%b %h want v1 lane0 11", bus_p.out_valid, bus_p.out_lane, bus_p.out_data); end
        wait_out(6, 6);
        idle(3);
        checks++;
        if (obs_p.size() != exp.size()) begin errors++; $display("FAIL t1_count got %0d want %0d", obs_p.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp[i]) begin errors++; $display("FAIL t1_byte%0d got %h want %h", i, obs_p[i], exp[i]); end
        end
        checks++;
        if (lm_cnt_p != 0) begin errors++; $display("FAIL t1_len_mismatch got %0d pulses want 0", lm_cnt_p); end
    endtask

    task automatic run_unequal();
        clear_mon();
        oready = 1'b1;
        put1(8'hA1, 1'b0); put1(8'hA2, 1'b0); put1(8'hA3, 1'b1);
        put2(8'hB1, 1'b1);
        wait_out(5, 4);
        idle(4);
    endtask

    task automatic test_unequal_pad();
        logic [9:0] exp[$];
        exp = '{10'h0A1, 10'h2B1, 10'h0A2, 10'h200, 10'h1A3};
        run_unequal();
        checks++;
        if (obs_p.size() != exp.size()) begin errors++; $display("FAIL t2_count got %0d want %0d", obs_p.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp[i]) begin errors++; $display("FAIL t2_byte%0d got %h want %h", i, obs_p[i], exp[i]); end
        end
        checks++;
        if (lm_cnt_p != 1) begin errors++; $display("FAIL t2_len_mismatch got %0d pulses want 1", lm_cnt_p); end
        checks++;
        if (lm_cyc_p != last_cyc_p + 1) begin errors++; $display("FAIL t2_lm_timing got cycle %0d want %0d", lm_cyc_p, last_cyc_p + 1); end
    endtask

    task automatic test_unequal_nopad();
        logic [9:0] exp[$];
        exp = '{10'h0A1, 10'h2B1, 10'h0A2, 10'h1A3};
        run_unequal();
        checks++;
        if (obs_n.size() != exp.size()) begin errors++; $display("FAIL t3_count got %0d want %0d", obs_n.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_n.size(); i++) begin
            checks++;
            if (obs_n[i] !== exp[i]) begin errors++; $display("FAIL t3_byte%0d got %h want %h", i, obs_n[i], exp[i]); end
        end
        checks++;
        if (lm_cnt_n != 1) begin errors++; $display("FAIL t3_len_mismatch got %0d pulses want 1", lm_cnt_n); end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp[$];
        logic [10:0] prev, cur;
        logic stalled = 1'b0;
        bit fin = 1'b0;
        prev = '0;
        for (int i = 0; i < 32; i++) begin
            exp.push_back({1'b0, 1'b0, 8'(8'h40 + i)});
            exp.push_back({1'b1, 1'(i == 31), 8'(8'h80 + i)});
        end
        clear_mon();
        oready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            put1(8'(8'h40 + i), i == 31);
            if (i == 30) begin
                checks++;
                if (bus_p.in_ready1 !== 1'b1) begin errors++; $display("FAIL t4_ready1_at31 got %b want 1", bus_p.in_ready1); end
            end
        end
        checks++;
        if (bus_p.in_ready1 !== 1'b0) begin errors++; $display("FAIL t4_full1_at32 got %b want 0", bus_p.in_ready1); end
        for (int i = 0; i < 32; i++) put2(8'(8'h80 + i), i == 31);
        checks++;
        if (bus_p.in_ready2 !== 1'b0) begin errors++; $display("FAIL t4_full2_at32 got %b want 0", bus_p.in_ready2); end
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk); #1;
            oready = ~oready;
            @(negedge clk);
            cur = {bus_p.out_valid, bus_p.out_lane, bus_p.out_last, bus_p.out_data};
            if (stalled) begin
                checks++;
                if (cur !== prev) begin errors++; $display("FAIL t4_hold got %h want %h", cur, prev); end
            end
            stalled = bus_p.out_valid && !oready;
            prev = cur;
            if (bus_p.out_valid && oready && bus_p.out_last) fin = 1'b1;
        end
        if (!fin) begin checks++; errors++; $display("FAIL t4_timeout got %0d bytes want 64", obs_p.size()); end
        @(posedge clk); #1;
        oready = 1'b1;
        idle(3);
        checks++;
        if (obs_p.size() != exp.size()) begin errors++; $display("FAIL t4_count got %0d want %0d", obs_p.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp[i]) begin errors++; $display("FAIL t4_byte%0d got %h want %h", i, obs_p[i], exp[i]); end
        end
    endtask

    task automatic test_oversize();
        logic [9:0] exp[$];
        exp = '{10'h031, 10'h2C1, 10'h032, 10'h2C2, 10'h033, 10'h3C3};
        clear_mon();
        oready = 1'b1;
        for (int i = 0; i < 40; i++) put1(8'(8'h60 + i), i == 39);
        idle(3);
        checks++;
        if (bus_p.err_ovf !== 1'b1) begin errors++; $display("FAIL t5_err_ovf got %b want 1", bus_p.err_ovf); end
        checks++;
        if (obs_p.size() != 0 || bus_p.out_valid !== 1'b0)
            begin errors++; $display("FAIL t5_no_output got %0d bytes valid %b want 0 0", obs_p.size(), bus_p.out_valid); end
        checks++;
        if (bus_p.in_ready1 !== 1'b1) begin errors++; $display("FAIL t5_ready1 got %b want 1", bus_p.in_ready1); end
        put1(8'h31, 1'b0); put1(8'h32, 1'b0); put1(8'h33, 1'b1);
        put2(8'hC1, 1'b0); put2(8'hC2, 1'b0); put2(8'hC3, 1'b1);
        wait_out(6, 6);
        idle(3);
        checks++;
        if (obs_p.size() != exp.size()) begin errors++; $display("FAIL t5_count got %0d want %0d", obs_p.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp[i]) begin errors++; $display("FAIL t5_byte%0d got %h want %h", i, obs_p[i], exp[i]); end
        end
        checks++;
        if (bus_p.err_ovf !== 1'b1) begin errors++; $display("FAIL t5_err_ovf_sticky got %b want 1", bus_p.err_ovf); end
    endtask

    task automatic test_reset_mid_emit();
        logic [9:0] exp[$];
        int n = 0;
        exp = '{10'h071, 10'h281, 10'h072, 10'h382};
        clear_mon();
        oready = 1'b1;
        put1(8'h51, 1'b0); put1(8'h52, 1'b1);
        put2(8'h61, 1'b0); put2(8'h62, 1'b1);
        @(negedge clk);
        while (!(bus_p.out_valid && bus_p.out_data == 8'h61) && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL t6_second_byte got %h valid %b want 61 valid 1", bus_p.out_data, bus_p.out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_p.out_valid, bus_n.out_valid, bus_p.err_ovf, bus_p.in_ready1, bus_p.in_ready2} !== 5'b00011)
            begin errors++; $display("FAIL t6_async_reset got vp%b vn%b ovf%b r%b%b want 0 0 0 11",
                bus_p.out_valid, bus_n.out_valid, bus_p.err_ovf, bus_p.in_ready1, bus_p.in_ready2); end
        @(negedge clk);
        rst = 1'b1;
        clear_mon();
        idle(6);
        checks++;
        if (obs_p.size() != 0 || bus_p.out_valid !== 1'b0)
            begin errors++; $display("FAIL t6_no_partial got %0d bytes valid %b want 0 0", obs_p.size(), bus_p.out_valid); end
        put1(8'h71, 1'b0); put1(8'h72, 1'b1);
        put2(8'h81, 1'b0); put2(8'h82, 1'b1);
        wait_out(4, 4);
        idle(3);
        checks++;
        if (obs_p.size() != exp.size()) begin errors++; $display("FAIL t6_count got %0d want %0d", obs_p.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_p.size(); i++) begin
            checks++;
            if (obs_p[i] !== exp[i]) begin errors++; $display("FAIL t6_byte%0d got %h want %h", i, obs_p[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_equal_frames();
        test_unequal_pad();
        test_unequal_nopad();
        test_backpressure();
        test_oversize();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
